mem_port_arbiter: RTL and testbench

Shares one single-port unified memory bus between the core's instruction-fetch port and data port. Requests are serviced one at a time through a three-state request/grant/response sequencer. The data port has priority, and a bounded-starvation counter protects instruction fetch. The block sits between the core's memory-facing ports and the memory or bus adapter, and drives the pipeline stall while either port waits.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between the instruction-fetch and data ports.
// Data wins collisions; a starvation counter forces fetch through after STARVE_LIMIT losses.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        Stall,
  output logic        arb_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic       owner_d;
  logic [3:0] starve_cnt;
  logic       i_live;
  logic       d_live;
  logic       pick_i;
  logic       pick_d;

  // A port's request is stale in the cycle its completion pulse is out.
  assign i_live = i_req && !i_valid;
  assign d_live = d_req && !d_valid;
  assign pick_i = i_live && (!d_live || (starve_cnt == LIMIT));
  assign pick_d = d_live && !pick_i;

  assign Stall = (i_req && !i_valid) || (d_req && !d_valid);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_i || pick_d) state_nxt = REQ;
      REQ:     if (m_gnt)            state_nxt = RSP;
      RSP:     if (m_rvalid)         state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      arb_err    <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_i) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            m_be       <= 4'hF;
            owner_d    <= 1'b0;
            starve_cnt <= '0;
          end else if (pick_d) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_be;
            owner_d <= 1'b1;
            if (i_live) starve_cnt <= starve_cnt + 4'd1;
          end
        end
        REQ: begin
          if (m_gnt) m_req <= 1'b0;
        end
        RSP: begin
          if (m_rvalid) begin
            if (owner_d) begin
              d_valid <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end else begin
              i_valid <= 1'b1;
              i_rdata <= m_rdata;
            end
          end
        end
        default: ;
      endcase
      // Responses outside RSP have no owner; flag and drop them.
      if (m_rvalid && (state != RSP)) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data read/write, starvation, stray response, reset.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        Stall;
  logic        arb_err;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .Stall(Stall), .arb_err(arb_err)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({m_req, m_we, m_addr, m_wdata, m_be} !== 70'd0) begin
      bad++; $display("FAIL reset_m got=%h exp=0", {m_req, m_we, m_addr, m_wdata, m_be});
    end
    total++;
    if ({i_valid, d_valid, i_rdata, d_rdata} !== 66'd0) begin
      bad++; $display("FAIL reset_port got=%h exp=0", {i_valid, d_valid, i_rdata, d_rdata});
    end
    total++;
    if ({arb_err, Stall} !== 2'b00) begin
      bad++; $display("FAIL reset_err_stall got=%b exp=00", {arb_err, Stall});
    end
    tick;
    tick;
    Reset_n = 1'b1;
  endtask

  task automatic test_single_fetch;
    tick;
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    total++;
    if (Stall !== 1'b1 || m_req !== 1'b0) begin
      bad++; $display("FAIL fetch_c0 got stall=%b m_req=%b exp stall=1 m_req=0", Stall, m_req);
    end
    tick;
    total++;
    if ({m_req, m_we, m_addr, m_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      bad++; $display("FAIL fetch_issue got req=%b we=%b addr=%h be=%h exp 1 0 00000100 f",
                      m_req, m_we, m_addr, m_be);
    end
    m_gnt = 1'b1;
    tick;
    total++;
    if (m_req !== 1'b0) begin
      bad++; $display("FAIL fetch_drop_req got=%b exp=0", m_req);
    end
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    tick;
    m_rvalid = 1'b0;
    total++;
    if (i_valid !== 1'b1 || i_rdata !== 32'hDEADBEEF || Stall !== 1'b0) begin
      bad++; $display("FAIL fetch_done got valid=%b rdata=%h stall=%b exp 1 deadbeef 0",
                      i_valid, i_rdata, Stall);
    end
    i_req = 1'b0;
    tick;
    total++;
    if (i_valid !== 1'b0 || d_valid !== 1'b0 || m_req !== 1'b0) begin
      bad++; $display("FAIL fetch_one_pulse got iv=%b dv=%b m_req=%b exp 0 0 0", i_valid, d_valid, m_req);
    end
  endtask

  task automatic test_stall;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick;
      if (c == 2) m_gnt = 1'b1;
      if (c == 3) m_gnt = 1'b0;
      if (c == 4) begin m_rvalid = 1'b1; m_rdata = 32'hCAFE0001; end
      #1;
      total++;
      if (Stall !== 1'b1) begin
        bad++; $display("FAIL stall_wait cycle=%0d got=%b exp=1", c, Stall);
      end
    end
    tick;
    m_rvalid = 1'b0;
    #1;
    total++;
    if (d_valid !== 1'b1 || Stall !== 1'b0 || d_rdata !== 32'hCAFE0001) begin
      bad++; $display("FAIL stall_done got dv=%b stall=%b rdata=%h exp 1 0 cafe0001", d_valid, Stall, d_rdata);
    end
    d_req = 1'b0;
  endtask

  task automatic test_write_wait;
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
    for (int c = 1; c <= 3; c++) begin
      tick;
      total++;
      if ({m_req, m_we, m_addr, m_wdata, m_be} !== {1'b1, 1'b1, 32'h2000, 32'h12345678, 4'b0011}) begin
        bad++; $display("FAIL write_hold cycle=%0d got req=%b we=%b addr=%h wdata=%h be=%b", c,
                        m_req, m_we, m_addr, m_wdata, m_be);
      end
      if (c == 3) m_gnt = 1'b1;
    end
    tick;
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBADBAD00;
    tick;
    m_rvalid = 1'b0;
    total++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hCAFE0001) begin
      bad++; $display("FAIL write_done got dv=%b rdata=%h exp 1 cafe0001", d_valid, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick;
    total++;
    if (d_valid !== 1'b0) begin
      bad++; $display("FAIL write_one_pulse got=%b exp=0", d_valid);
    end
  endtask

  // Both requests re-present together after every completion so each IDLE sees a collision.
  task automatic test_starvation;
    logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF;
    tick;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick;
      total++;
      if (m_req !== 1'b1 || m_addr !== (exp_d[n] ? 32'h200 : 32'h100)) begin
        bad++; $display("FAIL starve_order n=%0d got req=%b addr=%h exp_d=%b", n, m_req, m_addr, exp_d[n]);
      end
      m_gnt = 1'b1;
      tick;
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5000 + n;
      tick;
      m_rvalid = 1'b0;
      total++;
      if ({i_valid, d_valid} !== (exp_d[n] ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL starve_valid n=%0d got iv=%b dv=%b", n, i_valid, d_valid);
      end
      if (!exp_d[n]) begin
        total++;
        if (i_rdata !== 32'h5004) begin
          bad++; $display("FAIL starve_irdata got=%h exp=00005004", i_rdata);
        end
      end
      i_req = 1'b0; d_req = 1'b0;
      if (n < 5) begin
        tick;
        i_req = 1'b1; d_req = 1'b1;
      end
    end
    tick;
    total++;
    if (d_rdata !== 32'h5005 || m_req !== 1'b0) begin
      bad++; $display("FAIL starve_end got rdata=%h m_req=%b exp 00005005 0", d_rdata, m_req);
    end
  endtask

  task automatic test_stray;
    tick;
    m_rvalid = 1'b1; m_rdata = 32'h77777777;
    tick;
    m_rvalid = 1'b0;
    total++;
    if (arb_err !== 1'b1 || i_valid !== 1'b0 || d_valid !== 1'b0 || m_req !== 1'b0) begin
      bad++; $display("FAIL stray_flag got err=%b iv=%b dv=%b m_req=%b exp 1 0 0 0", arb_err, i_valid, d_valid, m_req);
    end
    i_req = 1'b1; i_addr = 32'h400;
    tick;
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h400) begin
      bad++; $display("FAIL stray_fetch_issue got req=%b addr=%h exp 1 00000400", m_req, m_addr);
    end
    m_gnt = 1'b1;
    tick;
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11112222;
    tick;
    m_rvalid = 1'b0;
    total++;
    if (i_valid !== 1'b1 || i_rdata !== 32'h11112222 || arb_err !== 1'b1) begin
      bad++; $display("FAIL stray_fetch_done got iv=%b rdata=%h err=%b exp 1 11112222 1", i_valid, i_rdata, arb_err);
    end
    i_req = 1'b0;
  endtask

  task automatic test_reset_midflight;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    tick;
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h500) begin
      bad++; $display("FAIL rst_issue got req=%b addr=%h exp 1 00000500", m_req, m_addr);
    end
    m_gnt = 1'b1;
    tick;
    m_gnt = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    total++;
    if ({m_req, m_we, m_addr, m_wdata, m_be, i_rdata, d_rdata, arb_err} !== 135'd0) begin
      bad++; $display("FAIL rst_async got m_addr=%h i_rdata=%h d_rdata=%h err=%b exp all 0",
                      m_addr, i_rdata, d_rdata, arb_err);
    end
    d_req = 1'b0;
    tick;
    Reset_n = 1'b1;
    total++;
    if (i_valid !== 1'b0 || d_valid !== 1'b0) begin
      bad++; $display("FAIL rst_no_pulse0 got iv=%b dv=%b exp 0 0", i_valid, d_valid);
    end
    tick;
    total++;
    if (i_valid !== 1'b0 || d_valid !== 1'b0 || m_req !== 1'b0) begin
      bad++; $display("FAIL rst_no_pulse1 got iv=%b dv=%b m_req=%b exp 0 0 0", i_valid, d_valid, m_req);
    end
    d_req = 1'b1; d_addr = 32'h600;
    tick;
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h600 || m_we !== 1'b0) begin
      bad++; $display("FAIL rst_new_issue got req=%b addr=%h we=%b exp 1 00000600 0", m_req, m_addr, m_we);
    end
    m_gnt = 1'b1;
    tick;
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h600DF00D;
    tick;
    m_rvalid = 1'b0;
    total++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h600DF00D) begin
      bad++; $display("FAIL rst_new_done got dv=%b rdata=%h exp 1 600df00d", d_valid, d_rdata);
    end
    d_req = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    test_stall;
    test_write_wait;
    test_starvation;
    test_stray;
    test_reset_midflight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
